// File: rtl/usr_seq_pkg.sv
// Shared types and constants for the universal-shift-register sequencer.
package usr_seq_pkg;

  localparam int unsigned USR_SEQ_WIDTH = 8;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } usr_seq_state_t;

endpackage

// File: rtl/usr_seq_counter.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module usr_seq_counter #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/usr_shift_sequencer.sv
// Command-driven controller for an external universal shift register.
// Optional macro USR_SEQ_CMD_CHECK_EN: reject over-long counts with a cmd_err pulse.
module usr_shift_sequencer
  import usr_seq_pkg::*;
#(
  parameter int unsigned WIDTH = USR_SEQ_WIDTH,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CW-1:0]    cmd_count,
  output logic             ser_valid,
  output logic             ser_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             usr_shift_left,
  output logic             usr_shift_right,
  output logic [WIDTH-1:0] usr_parallel_in,
  input  logic [WIDTH-1:0] usr_parallel_out
`ifdef USR_SEQ_CMD_CHECK_EN
  ,
  output logic             cmd_err
`endif
);

  localparam logic [CW-1:0] MAX_CNT = CW'(WIDTH);

  usr_seq_state_t   state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0]    cnt_val;
  logic             over;

  assign over = (cmd_count > MAX_CNT);

  // Counter is decremented from LOAD onward, so in SHIFT the zero flag
  // means the last shift has already been issued.
  usr_seq_counter #(
    .CW(CW)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

`ifdef USR_SEQ_CMD_CHECK_EN
  logic cmd_err_q, cmd_err_d;
  assign cnt_val = cmd_count;
`else
  assign cnt_val = over ? MAX_CNT : cmd_count;
`endif

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    dir_d    = dir_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
`ifdef USR_SEQ_CMD_CHECK_EN
    cmd_err_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
`ifdef USR_SEQ_CMD_CHECK_EN
          if (over) begin
            cmd_err_d = 1'b1;
          end else begin
            data_d   = cmd_data;
            dir_d    = cmd_dir;
            cnt_load = 1'b1;
            state_d  = LOAD;
          end
`else
          data_d   = cmd_data;
          dir_d    = cmd_dir;
          cnt_load = 1'b1;
          state_d  = LOAD;
`endif
        end
      end
      LOAD: begin
        if (cnt_zero) begin
          state_d = DONE;
        end else begin
          cnt_dec = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_zero) begin
          state_d = DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
    end
  end

`ifdef USR_SEQ_CMD_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_err_q <= 1'b0;
    end else begin
      cmd_err_q <= cmd_err_d;
    end
  end
  assign cmd_err = cmd_err_q;
`endif

  always_comb begin
    cmd_ready       = (state_q == IDLE);
    ser_valid       = (state_q == SHIFT);
    res_valid       = (state_q == DONE);
    res_data        = usr_parallel_out;
    usr_shift_left  = 1'b0;
    usr_shift_right = 1'b0;
    usr_parallel_in = usr_parallel_out;
    ser_out         = 1'b0;
    unique case (state_q)
      LOAD: usr_parallel_in = data_q;
      SHIFT: begin
        usr_shift_left  = (dir_q == DIR_LEFT);
        usr_shift_right = (dir_q == DIR_RIGHT);
        ser_out = (dir_q == DIR_LEFT) ? usr_parallel_out[WIDTH-1] : usr_parallel_out[0];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Directed bench: sequencer driving a behavioural universal shift register.
module tb_usr_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       cmd_dir;
  logic [3:0] cmd_count;
  logic       ser_valid;
  logic       ser_out;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       usr_shift_left;
  logic       usr_shift_right;
  logic [7:0] usr_parallel_in;
  logic [7:0] usr_parallel_out;
`ifdef USR_SEQ_CMD_CHECK_EN
  logic       cmd_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  usr_shift_sequencer #(.WIDTH(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_data         (cmd_data),
    .cmd_dir          (cmd_dir),
    .cmd_count        (cmd_count),
    .ser_valid        (ser_valid),
    .ser_out          (ser_out),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
    .usr_shift_left   (usr_shift_left),
    .usr_shift_right  (usr_shift_right),
    .usr_parallel_in  (usr_parallel_in),
    .usr_parallel_out (usr_parallel_out)
`ifdef USR_SEQ_CMD_CHECK_EN
    ,
    .cmd_err          (cmd_err)
`endif
  );

  // External universal shift register: left > right > load, zero fill, sync reset.
  logic [7:0] sr_q;
  always_ff @(posedge clk) begin
    if (rst)                  sr_q <= '0;
    else if (usr_shift_left)  sr_q <= {sr_q[6:0], 1'b0};
    else if (usr_shift_right) sr_q <= {1'b0, sr_q[7:1]};
    else                      sr_q <= usr_parallel_in;
  end
  assign usr_parallel_out = sr_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // bits[i] is the i-th serial bit expected out; n is the number of SHIFT cycles.
  task automatic do_cmd(input string tag, input logic [7:0] d, input logic dir,
                        input logic [3:0] cnt, input int n, input logic [7:0] bits,
                        input logic [7:0] res, input int hold);
    cmd_data  = d;
    cmd_dir   = dir;
    cmd_count = cnt;
    cmd_valid = 1'b1;
    chk({tag, "_accept_ready"}, cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk({tag, "_load_ready"}, cmd_ready, 0);
    chk({tag, "_load_serv"}, ser_valid, 0);
    chk({tag, "_load_pin"}, usr_parallel_in, d);
    chk({tag, "_load_shift"}, {usr_shift_left, usr_shift_right}, 0);
    tick();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_sh_serv"}, ser_valid, 1);
      chk({tag, "_sh_serout"}, ser_out, bits[i]);
      chk({tag, "_sh_left"}, usr_shift_left, !dir);
      chk({tag, "_sh_right"}, usr_shift_right, dir);
      chk({tag, "_sh_ready"}, cmd_ready, 0);
      tick();
    end
    chk({tag, "_done_resv"}, res_valid, 1);
    chk({tag, "_done_data"}, res_data, res);
    chk({tag, "_done_serv"}, ser_valid, 0);
    chk({tag, "_done_serout"}, ser_out, 0);
    chk({tag, "_done_shift"}, {usr_shift_left, usr_shift_right}, 0);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, "_hold_resv"}, res_valid, 1);
      chk({tag, "_hold_data"}, res_data, res);
      chk({tag, "_hold_ready"}, cmd_ready, 0);
      chk({tag, "_hold_reg"}, sr_q, res);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_post_resv"}, res_valid, 0);
    chk({tag, "_post_ready"}, cmd_ready, 1);
    chk({tag, "_post_reg"}, sr_q, res);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    cmd_dir   = 1'b0;
    cmd_count = '0;
    res_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_ready", cmd_ready, 1);
    chk("reset_serv", ser_valid, 0);
    chk("reset_resv", res_valid, 0);
    chk("reset_serout", ser_out, 0);
    chk("reset_reg", sr_q, 8'h00);
    tick();

    do_cmd("left3",  8'hA5, 1'b0, 4'd3, 3, 8'b0000_0101, 8'h28, 0);
    do_cmd("right2", 8'hA5, 1'b1, 4'd2, 2, 8'b0000_0001, 8'h29, 0);
    do_cmd("zero",   8'h3C, 1'b0, 4'd0, 0, 8'h00,        8'h3C, 0);
    do_cmd("drain",  8'hFF, 1'b0, 4'd8, 8, 8'hFF,        8'h00, 5);

    // Abort during the second SHIFT cycle of a five-shift command.
    cmd_data  = 8'hF0;
    cmd_dir   = 1'b0;
    cmd_count = 4'd5;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("abort_pre_serv", ser_valid, 1);
    chk("abort_pre_serout", ser_out, 1);
    rst = 1'b1;
    #1;
    chk("abort_serv", ser_valid, 0);
    chk("abort_serout", ser_out, 0);
    chk("abort_resv", res_valid, 0);
    tick();
    rst = 1'b0;
    chk("abort_reg", sr_q, 8'h00);
    chk("abort_ready", cmd_ready, 1);
    tick();
    chk("abort_idle_resv", res_valid, 0);
    chk("abort_idle_ready", cmd_ready, 1);

`ifdef USR_SEQ_CMD_CHECK_EN
    cmd_data  = 8'h81;
    cmd_dir   = 1'b0;
    cmd_count = 4'd9;
    cmd_valid = 1'b1;
    chk("err_accept_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("err_pulse", cmd_err, 1);
    chk("err_ready", cmd_ready, 1);
    chk("err_resv", res_valid, 0);
    tick();
    chk("err_clear", cmd_err, 0);
    chk("err_resv2", res_valid, 0);
    chk("err_serv", ser_valid, 0);
    chk("err_ready2", cmd_ready, 1);
`else
    do_cmd("sat9", 8'h81, 1'b0, 4'd9, 8, 8'h81, 8'h00, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
